// File: rtl/regs_access_ctrl.sv
// Register-file initiator: decode -> READ (1 cycle) -> held operand bundle; 1-entry writeback buffer drained in WRITE_PHASE.
// Backpressure: inst_ready only in IDLE, bundle held until op_ready, wb_ready low while the buffer is full.
module regs_access_ctrl #(
    parameter int PHASES      = 10,
    parameter int WRITE_PHASE = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        regWrite,
    output logic [4:0]  writeReg,
    output logic [31:0] writeData,
    output logic [4:0]  readReg1,
    output logic [4:0]  readReg2,
    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [31:0] op_rs1_val,
    output logic [31:0] op_rs2_val,
    output logic [4:0]  op_rd,
    output logic [3:0]  phase
);

    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

    localparam logic [3:0] LAST_PHASE = 4'(PHASES - 1);
    localparam logic [3:0] WR_PHASE   = 4'(WRITE_PHASE);

    state_t      state_q;
    state_t      state_d;
    logic [6:0]  opcode;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        buf_vld;
    logic [4:0]  buf_rd;
    logic [31:0] buf_dat;
    logic        drain;
    logic        inst_acc;
    logic [31:0] sel1;
    logic [31:0] sel2;

    function automatic logic [31:0] pick(input logic [4:0] rs, input logic [31:0] file_val,
                                         input logic hit_vld, input logic [4:0] hit_rd,
                                         input logic [31:0] hit_dat);
        logic [31:0] v;
        if (rs == 5'd0)
            v = 32'd0;
        else if (hit_vld && (hit_rd == rs))
            v = hit_dat;
        else
            v = file_val;
        return v;
    endfunction

    always_comb begin
        opcode  = inst[6:0];
        dec_rs1 = inst[19:15];
        dec_rs2 = inst[24:20];
        dec_rd  = inst[11:7];
        case (opcode)
            7'b0110111, 7'b0010111, 7'b1101111: begin
                dec_rs1 = 5'd0;
                dec_rs2 = 5'd0;
            end
            7'b0010011, 7'b0000011, 7'b1100111: dec_rs2 = 5'd0;
            7'b1100011, 7'b0100011:             dec_rd  = 5'd0;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        inst_ready = 1'b0;
        op_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                inst_ready = 1'b1;
                if (inst_valid)
                    state_d = READ;
            end
            READ: state_d = HOLD;
            HOLD: begin
                op_valid = 1'b1;
                if (op_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign inst_acc = inst_valid && inst_ready;

    // A buffered write still counts as current in its drain cycle, so the
    // bypass also covers a READ that coincides with the drain.
    assign sel1 = pick(readReg1, readData1, buf_vld, buf_rd, buf_dat);
    assign sel2 = pick(readReg2, readData2, buf_vld, buf_rd, buf_dat);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            readReg1   <= 5'd0;
            readReg2   <= 5'd0;
            op_rd      <= 5'd0;
            op_rs1_val <= 32'd0;
            op_rs2_val <= 32'd0;
        end else begin
            if (inst_acc) begin
                readReg1 <= dec_rs1;
                readReg2 <= dec_rs2;
                op_rd    <= dec_rd;
            end
            if (state_q == READ) begin
                op_rs1_val <= sel1;
                op_rs2_val <= sel2;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            phase <= 4'd0;
        else if (phase == LAST_PHASE)
            phase <= 4'd0;
        else
            phase <= phase + 4'd1;
    end

    assign drain    = buf_vld && (phase == WR_PHASE);
    assign wb_ready = !buf_vld;

    // Writes to x0 are accepted but never stored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_vld <= 1'b0;
            buf_rd  <= 5'd0;
            buf_dat <= 32'd0;
        end else if (drain) begin
            buf_vld <= 1'b0;
        end else if (wb_valid && wb_ready && (wb_rd != 5'd0)) begin
            buf_vld <= 1'b1;
            buf_rd  <= wb_rd;
            buf_dat <= wb_data;
        end
    end

    assign regWrite  = drain;
    assign writeReg  = buf_vld ? buf_rd  : 5'd0;
    assign writeData = buf_vld ? buf_dat : 32'd0;

endmodule

// File: tb/tb_regs_access_ctrl.sv
// Scoreboarded bench for regs_access_ctrl: directed instruction/writeback vectors,
// expected bundles and register-file writes are queued and popped by monitors.
module tb_regs_access_ctrl;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } op_exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] dat;
    } wb_exp_t;

    logic        clock;
    logic        reset;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_rs1_val;
    logic [31:0] op_rs2_val;
    logic [4:0]  op_rd;
    logic [3:0]  phase;

    logic        pl_we;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;
    logic [31:0] rf [32];

    op_exp_t opq[$];
    wb_exp_t wbq[$];
    int total;
    int bad;

    regs_access_ctrl #(.PHASES(10), .WRITE_PHASE(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .regWrite   (regWrite),
        .writeReg   (writeReg),
        .writeData  (writeData),
        .readReg1   (readReg1),
        .readReg2   (readReg2),
        .readData1  (readData1),
        .readData2  (readData2),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_rs1_val (op_rs1_val),
        .op_rs2_val (op_rs2_val),
        .op_rd      (op_rd),
        .phase      (phase)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural register file, written by the DUT and by bench preloads.
    always @(posedge clock) begin
        if (regWrite)
            rf[writeReg] <= writeData;
        if (pl_we)
            rf[pl_addr] <= pl_data;
    end
    assign readData1 = rf[readReg1];
    assign readData2 = rf[readReg2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset && op_valid && op_ready) begin
            op_exp_t e;
            chk("op_q_nonempty", 32'(opq.size() > 0), 32'd1);
            if (opq.size() > 0) begin
                e = opq.pop_front();
                chk("op_rs1_val", op_rs1_val, e.a);
                chk("op_rs2_val", op_rs2_val, e.b);
                chk("op_rd", 32'(op_rd), 32'(e.rd));
            end
        end
    end

    always @(negedge clock) begin
        if (reset && regWrite) begin
            wb_exp_t e;
            chk("wb_phase", 32'(phase), 32'd2);
            chk("wb_q_nonempty", 32'(wbq.size() > 0), 32'd1);
            if (wbq.size() > 0) begin
                e = wbq.pop_front();
                chk("wb_reg", 32'(writeReg), 32'(e.rd));
                chk("wb_data", writeData, e.dat);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        while (32'(phase) != p && n < 20) begin
            tick();
            n++;
        end
        chk("wait_phase", 32'(phase), p);
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        tick();
        pl_we   = 1'b0;
    endtask

    task automatic issue(input logic [31:0] word, input logic [31:0] e1, input logic [31:0] e2,
                         input logic [4:0] erd, input bit push);
        int n = 0;
        op_exp_t e;
        while (!inst_ready && n < 20) begin
            tick();
            n++;
        end
        chk("issue_ready", 32'(inst_ready), 32'd1);
        if (push) begin
            e.a = e1;
            e.b = e2;
            e.rd = erd;
            opq.push_back(e);
        end
        inst       = word;
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
    endtask

    task automatic offer_wb(input logic [4:0] rd, input logic [31:0] d, input bit push);
        wb_exp_t e;
        if (push) begin
            e.rd = rd;
            e.dat = d;
            wbq.push_back(e);
        end
        wb_rd    = rd;
        wb_data  = d;
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_phase"}, 32'(phase), 32'd0);
        chk({tag, "_regWrite"}, 32'(regWrite), 32'd0);
        chk({tag, "_writeReg"}, 32'(writeReg), 32'd0);
        chk({tag, "_writeData"}, writeData, 32'd0);
        chk({tag, "_readReg1"}, 32'(readReg1), 32'd0);
        chk({tag, "_readReg2"}, 32'(readReg2), 32'd0);
        chk({tag, "_op_valid"}, 32'(op_valid), 32'd0);
        chk({tag, "_op_rs1"}, op_rs1_val, 32'd0);
        chk({tag, "_op_rs2"}, op_rs2_val, 32'd0);
        chk({tag, "_op_rd"}, 32'(op_rd), 32'd0);
        chk({tag, "_inst_ready"}, 32'(inst_ready), 32'd1);
        chk({tag, "_wb_ready"}, 32'(wb_ready), 32'd1);
    endtask

    localparam logic [31:0] ADD_X3_X1_X2  = 32'h002081B3;
    localparam logic [31:0] ADDI_X4_X1_5  = 32'h00508213;
    localparam logic [31:0] LUI_X3        = 32'h123451B7;
    localparam logic [31:0] BEQ_X1_X2     = 32'h00208463;

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b0;
        inst_valid = 1'b0;
        inst       = 32'd0;
        wb_valid   = 1'b0;
        wb_rd      = 5'd0;
        wb_data    = 32'd0;
        op_ready   = 1'b0;
        pl_we      = 1'b0;
        pl_addr    = 5'd0;
        pl_data    = 32'd0;

        #2;
        chk_reset_vals("rst");
        @(negedge clock);
        reset = 1'b1;
        chk("rel_phase", 32'(phase), 32'd0);

        // wb x5 offered in phase 0, must write only in the phase-2 cycle
        offer_wb(5'd5, 32'hDEADBEEF, 1'b1);
        chk("t1_wb_ready_low", 32'(wb_ready), 32'd0);
        chk("t1_phase1_nowrite", 32'(regWrite), 32'd0);
        tick();
        chk("t1_regWrite", 32'(regWrite), 32'd1);
        chk("t1_writeReg", 32'(writeReg), 32'd5);
        chk("t1_writeData", writeData, 32'hDEADBEEF);
        tick();
        chk("t1_phase3", 32'(phase), 32'd3);
        chk("t1_wb_ready_back", 32'(wb_ready), 32'd1);
        chk("t1_regWrite_off", 32'(regWrite), 32'd0);

        // write to x0 is swallowed
        offer_wb(5'd0, 32'h00001234, 1'b0);
        chk("t2_wb_ready", 32'(wb_ready), 32'd1);
        for (int i = 0; i < 20; i++) begin
            chk("t2_no_write", 32'(regWrite), 32'd0);
            tick();
        end

        preload(5'd1, 32'd1);
        preload(5'd2, 32'd2);
        preload(5'd3, 32'h33);
        preload(5'd8, 32'h88);

        // plain add from the register file
        op_ready = 1'b1;
        issue(ADD_X3_X1_X2, 32'd1, 32'd2, 5'd3, 1'b1);
        chk("t3_read_inst_ready", 32'(inst_ready), 32'd0);
        chk("t3_readReg1", 32'(readReg1), 32'd1);
        chk("t3_readReg2", 32'(readReg2), 32'd2);
        chk("t3_read_op_valid", 32'(op_valid), 32'd0);
        tick();
        chk("t3_op_valid", 32'(op_valid), 32'd1);
        tick();
        chk("t3_idle_ready", 32'(inst_ready), 32'd1);

        // pending x1 bypassed into rs1
        wait_phase(5);
        offer_wb(5'd1, 32'h55, 1'b1);
        issue(ADD_X3_X1_X2, 32'h55, 32'd2, 5'd3, 1'b1);
        tick();
        tick();

        // READ coincides with the drain cycle of x2
        wait_phase(3);
        wait_phase(0);
        offer_wb(5'd2, 32'h77, 1'b1);
        chk("t4b_phase", 32'(phase), 32'd1);
        issue(ADD_X3_X1_X2, 32'h55, 32'h77, 5'd3, 1'b1);
        chk("t4b_drain_in_read", 32'(regWrite), 32'd1);
        tick();
        tick();

        // decode masking: lui drops rs1/rs2, beq drops rd
        issue(LUI_X3, 32'd0, 32'd0, 5'd3, 1'b1);
        issue(BEQ_X1_X2, 32'h55, 32'h77, 5'd0, 1'b1);
        tick();
        tick();

        // HOLD stall with op_ready low; addi must not read x5
        op_ready = 1'b0;
        issue(ADDI_X4_X1_5, 32'h55, 32'd0, 5'd4, 1'b1);
        chk("t5_readReg2", 32'(readReg2), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", 32'(op_valid), 32'd1);
            chk("t5_hold_inst_ready", 32'(inst_ready), 32'd0);
            chk("t5_hold_rs1", op_rs1_val, 32'h55);
            chk("t5_hold_rs2", op_rs2_val, 32'd0);
            chk("t5_hold_rd", 32'(op_rd), 32'd4);
            tick();
        end
        op_ready = 1'b1;
        tick();
        chk("t5_released_valid", 32'(op_valid), 32'd0);
        chk("t5_released_ready", 32'(inst_ready), 32'd1);

        // async reset in HOLD with a write pending
        wait_phase(4);
        offer_wb(5'd6, 32'h66, 1'b0);
        op_ready = 1'b0;
        issue(ADD_X3_X1_X2, 32'd0, 32'd0, 5'd3, 1'b0);
        tick();
        chk("t6_hold", 32'(op_valid), 32'd1);
        chk("t6_pending", 32'(wb_ready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("t6_rst");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        op_ready = 1'b1;
        chk("t6_phase0", 32'(phase), 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t6_phase_run", 32'(phase), 32'((i + 1) % 10));
            chk("t6_no_write", 32'(regWrite), 32'd0);
        end

        chk("end_wbq_empty", 32'(wbq.size()), 32'd0);
        chk("end_opq_empty", 32'(opq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
